mirror_line_buf: RTL and testbench

- Parametrised, double-buffered horizontal line reverser on the CCD pixel path, placed between the CCD-to-RGB conversion and the downstream frame store or VGA path.
- Packs NUM_CH channels of DATA_W bits into one wide pixel.
- Writes each incoming line into one of two RAM banks (ping-pong) and replays the completed line, mirrored or straight, while the next line is captured.
- Detects short and long lines; malformed lines are dropped or truncated and flagged.

---
 rtl/mirror_pkg.sv | 18 +
 rtl/mirror_bank_ram.sv | 28 ++
 rtl/mirror_line_buf.sv | 143 ++++++++++++++
 tb/tb_mirror_line_buf.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mirror_pkg.sv
// Shared defaults, read-side FSM states and the channel packing helper
// used by the CCD line mirror.
package mirror_pkg;

  localparam int DEF_DATA_W = 10;
  localparam int DEF_NUM_CH = 3;
  localparam int DEF_LINE_W = 320;

  typedef enum logic {IDLE, READ} rdState_e;

  // Channel 0 sits in the top DATA_W bits of a packed pixel.
  function automatic int unsigned chLsb(input int unsigned ch,
                                        input int unsigned dataW,
                                        input int unsigned numCh);
    return (numCh - 1 - ch) * dataW;
  endfunction

endpackage

// File: rtl/mirror_bank_ram.sv
// Two-bank simple dual-port pixel RAM with a registered read port; the
// address MSB selects the bank.
module mirror_bank_ram
  import mirror_pkg::*;
#(
  parameter int WIDTH = DEF_DATA_W * DEF_NUM_CH,
  parameter int AW    = 10
) (
  input  logic             clock_i,
  input  logic             wrEn_i,
  input  logic [AW-1:0]    wrAddr_i,
  input  logic [WIDTH-1:0] wrData_i,
  input  logic [AW-1:0]    rdAddr_i,
  output logic [WIDTH-1:0] rdData_o
);

  // Spans the full bank+index space so the bank bit can stay a plain MSB.
  logic [WIDTH-1:0] mem_q [2**AW];
  logic [WIDTH-1:0] rdData_q;

  always_ff @(posedge clock_i) begin
    if (wrEn_i) mem_q[wrAddr_i] <= wrData_i;
    rdData_q <= mem_q[rdAddr_i];
  end

  assign rdData_o = rdData_q;

endmodule

// File: rtl/mirror_line_buf.sv
// Ping-pong line buffer that replays each completed CCD line mirrored or
// straight while the next line is captured; malformed lines raise oLINE_ERR.
module mirror_line_buf
  import mirror_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic                     iCCD_PIXCLK,
  input  logic                     iRST_N,
  input  logic [NUM_CH*DATA_W-1:0] iCCD_DATA,
  input  logic                     iCCD_DVAL,
  input  logic                     iMIRROR,
  output logic [NUM_CH*DATA_W-1:0] oCCD_DATA,
  output logic                     oCCD_DVAL,
  output logic                     oLINE_ERR
);

  localparam int ADDR_W = $clog2(LINE_W);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int PIX_W  = NUM_CH * DATA_W;

  logic [CNT_W-1:0]  wrCnt_q, wrCnt_d;
  logic              wrBank_q, wrBank_d;
  logic              extra_q, extra_d;
  logic              lineErr_q, lineErr_d;
  logic              wrEn, lineDone;

  rdState_e          state_q;
  logic [ADDR_W-1:0] rdCnt_q;
  logic              rdBank_q, rdMirror_q, pend_q;
  logic              lastRd;
  logic [ADDR_W-1:0] rdIdx;

  logic              rdVld_q, oDval_q;
  logic [PIX_W-1:0]  oData_q, ramRdData;

  always_comb begin
    wrEn      = iCCD_DVAL && (wrCnt_q < CNT_W'(LINE_W));
    lineDone  = wrEn && (wrCnt_q == CNT_W'(LINE_W - 1));
    wrCnt_d   = wrCnt_q;
    wrBank_d  = wrBank_q;
    extra_d   = extra_q;
    lineErr_d = 1'b0;
    if (!iCCD_DVAL) begin
      wrCnt_d   = '0;
      extra_d   = 1'b0;
      lineErr_d = (wrCnt_q != '0) && (wrCnt_q < CNT_W'(LINE_W));
    end else if (wrEn) begin
      wrCnt_d = wrCnt_q + CNT_W'(1);
      if (lineDone) wrBank_d = ~wrBank_q;
    end else if (!extra_q) begin
      extra_d   = 1'b1;
      lineErr_d = 1'b1;
    end
  end

  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wrCnt_q   <= '0;
      wrBank_q  <= 1'b0;
      extra_q   <= 1'b0;
      lineErr_q <= 1'b0;
    end else begin
      wrCnt_q   <= wrCnt_d;
      wrBank_q  <= wrBank_d;
      extra_q   <= extra_d;
      lineErr_q <= lineErr_d;
    end
  end

  assign lastRd = (state_q == READ) && (rdCnt_q == ADDR_W'(LINE_W - 1));

  // A completion arriving during the final read slot restarts READ directly.
  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      rdCnt_q    <= '0;
      rdBank_q   <= 1'b0;
      rdMirror_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      if (lineDone) begin
        rdBank_q   <= wrBank_q;
        rdMirror_q <= iMIRROR;
      end
      case (state_q)
        IDLE: begin
          if (lineDone) begin
            state_q <= READ;
            rdCnt_q <= '0;
          end
        end
        READ: begin
          if (lastRd) begin
            if (lineDone || pend_q) begin
              rdCnt_q <= '0;
              pend_q  <= 1'b0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            rdCnt_q <= rdCnt_q + ADDR_W'(1);
            if (lineDone) pend_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rdIdx = rdMirror_q ? (ADDR_W'(LINE_W - 1) - rdCnt_q) : rdCnt_q;

  mirror_bank_ram #(
    .WIDTH (PIX_W),
    .AW    (ADDR_W + 1)
  ) u_ram (
    .clock_i  (iCCD_PIXCLK),
    .wrEn_i   (wrEn),
    .wrAddr_i ({wrBank_q, wrCnt_q[ADDR_W-1:0]}),
    .wrData_i (iCCD_DATA),
    .rdAddr_i ({rdBank_q, rdIdx}),
    .rdData_o (ramRdData)
  );

  always_ff @(posedge iCCD_PIXCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      rdVld_q <= 1'b0;
      oDval_q <= 1'b0;
      oData_q <= '0;
    end else begin
      rdVld_q <= (state_q == READ);
      oDval_q <= rdVld_q;
      if (rdVld_q) oData_q <= ramRdData;
    end
  end

  assign oCCD_DATA = oData_q;
  assign oCCD_DVAL = oDval_q;
  assign oLINE_ERR = lineErr_q;

endmodule

// File: tb/tb_mirror_line_buf.sv
// Randomised bench for mirror_line_buf: a line-level reference model predicts
// every output cycle; a second instance covers a 1x8-bit, 640-pixel config.
module tb_mirror_line_buf;
  import mirror_pkg::*;

  localparam int DW  = 10;
  localparam int NC  = 3;
  localparam int LW  = 320;
  localparam int PW  = DW * NC;
  localparam int LW2 = 640;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic [PW-1:0] data = '0;
  logic          dval = 1'b0;
  logic          mirror = 1'b0;
  logic [PW-1:0] oData;
  logic          oDval, oErr;

  logic [7:0]    d2 = '0;
  logic          v2 = 1'b0;
  logic          m2 = 1'b0;
  logic [7:0]    oData2;
  logic          oDval2, oErr2;

  int errors = 0;
  int checks = 0;

  logic          stimV[$];
  logic [PW-1:0] stimD[$];
  logic          stimM[$];
  logic          expV[], expE[], obsV[], obsE[];
  logic [PW-1:0] expD[], obsD[];
  logic [PW-1:0] lastOut = '0;

  always #5 clk = ~clk;

  mirror_line_buf #(.DATA_W(DW), .NUM_CH(NC), .LINE_W(LW)) dut (
    .iCCD_PIXCLK (clk),
    .iRST_N      (rstN),
    .iCCD_DATA   (data),
    .iCCD_DVAL   (dval),
    .iMIRROR     (mirror),
    .oCCD_DATA   (oData),
    .oCCD_DVAL   (oDval),
    .oLINE_ERR   (oErr)
  );

  mirror_line_buf #(.DATA_W(8), .NUM_CH(1), .LINE_W(LW2)) dut2 (
    .iCCD_PIXCLK (clk),
    .iRST_N      (rstN),
    .iCCD_DATA   (d2),
    .iCCD_DVAL   (v2),
    .iMIRROR     (m2),
    .oCCD_DATA   (oData2),
    .oCCD_DVAL   (oDval2),
    .oLINE_ERR   (oErr2)
  );

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [PW-1:0] randPix();
    logic [PW-1:0] p;
    p = '0;
    for (int ch = 0; ch < NC; ch++)
      p |= PW'(DW'($urandom)) << chLsb(ch, DW, NC);
    return p;
  endfunction

  task automatic clearStim();
    stimV.delete(); stimD.delete(); stimM.delete();
  endtask

  task automatic addIdle(input int n);
    for (int k = 0; k < n; k++) begin
      stimV.push_back(1'b0); stimD.push_back(randPix()); stimM.push_back(1'($urandom));
    end
  endtask

  // Mirror is random on every pixel except the completing one.
  task automatic addLine(input int len, input bit mir, input bit useIdx);
    for (int k = 0; k < len; k++) begin
      stimV.push_back(1'b1);
      stimD.push_back(useIdx ? PW'(k) : randPix());
      stimM.push_back((k == LW - 1) ? mir : 1'($urandom));
    end
  endtask

  // Line-level model: each DVAL run is a line, judged only by its length.
  task automatic buildExpected();
    int n, i, s, len, c;
    logic [PW-1:0] hold;
    n = stimV.size();
    expV = new[n]; expE = new[n]; expD = new[n];
    for (int j = 0; j < n; j++) begin expV[j] = 1'b0; expE[j] = 1'b0; expD[j] = '0; end
    i = 0;
    while (i < n) begin
      if (!stimV[i]) begin i++; continue; end
      s = i;
      while (i < n && stimV[i]) i++;
      len = i - s;
      if (len < LW) begin
        if (s + len < n) expE[s + len] = 1'b1;
      end else begin
        c = s + LW - 1;
        for (int k = 0; k < LW; k++)
          if (c + 2 + k < n) begin
            expV[c + 2 + k] = 1'b1;
            expD[c + 2 + k] = stimM[c] ? stimD[s + LW - 1 - k] : stimD[s + k];
          end
        if (len > LW && s + LW < n) expE[s + LW] = 1'b1;
      end
    end
    hold = lastOut;
    for (int j = 0; j < n; j++) begin
      if (expV[j]) hold = expD[j];
      else expD[j] = hold;
    end
    lastOut = hold;
  endtask

  // obs[j] is what the outputs show after the edge that sampled stim[j].
  task automatic runSeq();
    int n;
    n = stimV.size();
    obsV = new[n]; obsE = new[n]; obsD = new[n];
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin obsV[i-1] = oDval; obsE[i-1] = oErr; obsD[i-1] = oData; end
      if (i < n) begin dval = stimV[i]; data = stimD[i]; mirror = stimM[i]; end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (oDval !== 1'b0) begin errors++; $display("[TB] FAIL reset_dval: got %b want 0", oDval); end
    checks++; if (oData !== '0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", oData); end
    checks++; if (oErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b want 0", oErr); end
    checks++; if (oDval2 !== 1'b0 || oData2 !== 8'h0) begin errors++; $display("[TB] FAIL reset_alt: got %b/%h want 0/00", oDval2, oData2); end
    rstN = 1'b1;
    lastOut = '0;
    @(negedge clk);
  endtask

  task automatic test_mirror_line();
    clearStim(); addIdle(2); addLine(LW, 1'b1, 1'b1); addIdle(LW + 6);
    buildExpected(); runSeq();
    for (int j = 0; j < obsV.size(); j++) begin
      checks++; if (obsV[j] !== expV[j]) begin errors++; $display("[TB] FAIL mirror_dval c%0d: got %b want %b", j, obsV[j], expV[j]); end
      checks++; if (obsD[j] !== expD[j]) begin errors++; $display("[TB] FAIL mirror_data c%0d: got %0d want %0d", j, obsD[j], expD[j]); end
      checks++; if (obsE[j] !== expE[j]) begin errors++; $display("[TB] FAIL mirror_err c%0d: got %b want %b", j, obsE[j], expE[j]); end
    end
  endtask

  task automatic test_straight_line();
    clearStim(); addIdle(2); addLine(LW, 1'b0, 1'b1); addIdle(LW + 6);
    buildExpected(); runSeq();
    for (int j = 0; j < obsV.size(); j++) begin
      checks++; if (obsV[j] !== expV[j]) begin errors++; $display("[TB] FAIL straight_dval c%0d: got %b want %b", j, obsV[j], expV[j]); end
      checks++; if (obsD[j] !== expD[j]) begin errors++; $display("[TB] FAIL straight_data c%0d: got %0d want %0d", j, obsD[j], expD[j]); end
      checks++; if (obsE[j] !== expE[j]) begin errors++; $display("[TB] FAIL straight_err c%0d: got %b want %b", j, obsE[j], expE[j]); end
    end
  endtask

  task automatic test_back_to_back();
    int nValid;
    clearStim(); addIdle(2);
    addLine(LW, 1'b1, 1'b0); addIdle(1);
    addLine(LW, 1'b0, 1'b0); addIdle(1);
    addLine(LW, 1'b1, 1'b0); addIdle(LW + 6);
    buildExpected(); runSeq();
    nValid = 0;
    for (int j = 0; j < obsV.size(); j++) begin
      if (obsV[j] === 1'b1) nValid++;
      checks++; if (obsV[j] !== expV[j]) begin errors++; $display("[TB] FAIL b2b_dval c%0d: got %b want %b", j, obsV[j], expV[j]); end
      checks++; if (obsD[j] !== expD[j]) begin errors++; $display("[TB] FAIL b2b_data c%0d: got %h want %h", j, obsD[j], expD[j]); end
      checks++; if (obsE[j] !== expE[j]) begin errors++; $display("[TB] FAIL b2b_err c%0d: got %b want %b", j, obsE[j], expE[j]); end
    end
    checks++; if (nValid != 3 * LW) begin errors++; $display("[TB] FAIL b2b_count: got %0d want %0d", nValid, 3 * LW); end
  endtask

  task automatic test_short_line();
    clearStim(); addIdle(2); addLine(200, 1'b1, 1'b0); addIdle(3);
    addLine(LW, 1'b1, 1'b0); addIdle(LW + 6);
    buildExpected(); runSeq();
    for (int j = 0; j < obsV.size(); j++) begin
      checks++; if (obsV[j] !== expV[j]) begin errors++; $display("[TB] FAIL short_dval c%0d: got %b want %b", j, obsV[j], expV[j]); end
      checks++; if (obsD[j] !== expD[j]) begin errors++; $display("[TB] FAIL short_data c%0d: got %h want %h", j, obsD[j], expD[j]); end
      checks++; if (obsE[j] !== expE[j]) begin errors++; $display("[TB] FAIL short_err c%0d: got %b want %b", j, obsE[j], expE[j]); end
    end
  endtask

  task automatic test_long_line();
    clearStim(); addIdle(2); addLine(LW + 10, 1'b1, 1'b0); addIdle(LW + 6);
    buildExpected(); runSeq();
    for (int j = 0; j < obsV.size(); j++) begin
      checks++; if (obsV[j] !== expV[j]) begin errors++; $display("[TB] FAIL long_dval c%0d: got %b want %b", j, obsV[j], expV[j]); end
      checks++; if (obsD[j] !== expD[j]) begin errors++; $display("[TB] FAIL long_data c%0d: got %h want %h", j, obsD[j], expD[j]); end
      checks++; if (obsE[j] !== expE[j]) begin errors++; $display("[TB] FAIL long_err c%0d: got %b want %b", j, obsE[j], expE[j]); end
    end
  endtask

  task automatic test_reset_mid_readout();
    // Stop the sequence exactly when output pixel 150 is on the port.
    clearStim(); addIdle(2); addLine(LW, 1'b1, 1'b0); addIdle(152);
    buildExpected(); runSeq();
    for (int j = 0; j < obsV.size(); j++) begin
      checks++; if (obsV[j] !== expV[j] || obsD[j] !== expD[j]) begin errors++; $display("[TB] FAIL midrst_pre c%0d: got %b/%h want %b/%h", j, obsV[j], obsD[j], expV[j], expD[j]); end
    end
    rstN = 1'b0;
    #1;
    checks++; if (oDval !== 1'b0) begin errors++; $display("[TB] FAIL midrst_dval: got %b want 0", oDval); end
    checks++; if (oData !== '0) begin errors++; $display("[TB] FAIL midrst_data: got %h want 0", oData); end
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    lastOut = '0;
    clearStim(); addIdle(2); addLine(LW, 1'b0, 1'b0); addIdle(LW + 6);
    buildExpected(); runSeq();
    for (int j = 0; j < obsV.size(); j++) begin
      checks++; if (obsV[j] !== expV[j]) begin errors++; $display("[TB] FAIL midrst_post_dval c%0d: got %b want %b", j, obsV[j], expV[j]); end
      checks++; if (obsD[j] !== expD[j]) begin errors++; $display("[TB] FAIL midrst_post_data c%0d: got %h want %h", j, obsD[j], expD[j]); end
      checks++; if (obsE[j] !== expE[j]) begin errors++; $display("[TB] FAIL midrst_post_err c%0d: got %b want %b", j, obsE[j], expE[j]); end
    end
  endtask

  task automatic test_alt_config();
    logic [7:0] lineA[LW2];
    logic [7:0] lineB[LW2];
    logic       v2s[$];
    logic [7:0] d2s[$];
    logic       m2s[$];
    logic       ov[], oe[];
    logic [7:0] od[];
    int n, startA, startB, nValid;
    for (int k = 0; k < LW2; k++) begin lineA[k] = 8'($urandom); lineB[k] = 8'($urandom); end
    for (int k = 0; k < 2; k++) begin v2s.push_back(1'b0); d2s.push_back(8'h0); m2s.push_back(1'b0); end
    for (int k = 0; k < LW2; k++) begin v2s.push_back(1'b1); d2s.push_back(lineA[k]); m2s.push_back(1'b1); end
    v2s.push_back(1'b0); d2s.push_back(8'h0); m2s.push_back(1'b1);
    for (int k = 0; k < LW2; k++) begin v2s.push_back(1'b1); d2s.push_back(lineB[k]); m2s.push_back(1'b0); end
    for (int k = 0; k < LW2 + 6; k++) begin v2s.push_back(1'b0); d2s.push_back(8'h0); m2s.push_back(1'b0); end
    n = v2s.size();
    ov = new[n]; oe = new[n]; od = new[n];
    for (int i = 0; i <= n; i++) begin
      @(negedge clk);
      if (i > 0) begin ov[i-1] = oDval2; oe[i-1] = oErr2; od[i-1] = oData2; end
      if (i < n) begin v2 = v2s[i]; d2 = d2s[i]; m2 = m2s[i]; end
    end
    // Line A completes at index 2+LW2-1, line B one gap cycle after A ends.
    startA = 2 + LW2 - 1 + 2;
    startB = 2 + LW2 + 1 + LW2 - 1 + 2;
    nValid = 0;
    for (int j = 0; j < n; j++) begin
      if (ov[j] === 1'b1) nValid++;
      checks++; if (oe[j] !== 1'b0) begin errors++; $display("[TB] FAIL alt_err c%0d: got %b want 0", j, oe[j]); end
    end
    checks++; if (nValid != 2 * LW2) begin errors++; $display("[TB] FAIL alt_count: got %0d want %0d", nValid, 2 * LW2); end
    for (int k = 0; k < LW2; k++) begin
      checks++; if (ov[startA + k] !== 1'b1 || od[startA + k] !== lineA[LW2 - 1 - k]) begin errors++; $display("[TB] FAIL alt_mirror k%0d: got %b/%h want 1/%h", k, ov[startA + k], od[startA + k], lineA[LW2 - 1 - k]); end
      checks++; if (ov[startB + k] !== 1'b1 || od[startB + k] !== lineB[k]) begin errors++; $display("[TB] FAIL alt_straight k%0d: got %b/%h want 1/%h", k, ov[startB + k], od[startB + k], lineB[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_mirror_line();
    test_straight_line();
    test_back_to_back();
    test_short_line();
    test_long_line();
    test_reset_mid_readout();
    test_alt_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
